i2c_xfer_sequencer: RTL

Autonomous transaction engine that drives the i2c_master_byte_ctrl command interface in place of software. It accepts one whole I2C transaction (7-bit address, direction, byte count) and issues START+address, write or read data bytes with correct ACK/NACK, then STOP. Write data enters and read data leaves on valid/ready streams, and each transaction ends with a one-cycle completion report.

---
 rtl/i2c_xfer_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_xfer_sequencer.sv
// i2c_xfer_sequencer: runs one whole I2C transaction on the byte controller.
// The transaction is START+address, then write or read data bytes, then STOP.
//
// Ports:
//   HCLK, HRESET           clock, async active-high reset
//   req_*                  transaction request (addr, rnw, len), valid/ready
//   wdata_*                write byte stream in (ready is a take pulse)
//   rdata_*                read byte stream out (valid held until ready)
//   done_*                 one-cycle completion report (status, byte count)
//   bc_*                   command/response interface of the byte controller
module i2c_xfer_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_addr,
    input  logic             req_rnw,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [7:0]       wdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [7:0]       rdata,
    output logic             done_valid,
    output logic [1:0]       done_status,
    output logic [LEN_W-1:0] done_count,
    output logic             bc_start,
    output logic             bc_stop,
    output logic             bc_read,
    output logic             bc_write,
    output logic             bc_ack_in,
    output logic [7:0]       bc_din,
    input  logic             bc_cmd_ack,
    input  logic             bc_ack_out,
    input  logic [7:0]       bc_dout,
    input  logic             bc_al
);

    typedef enum logic [2:0] {
        IDLE, ADDR, WGET, WBYTE, RBYTE, RPUSH, STOP, DONE
    } state_t;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ANACK = 2'b01;
    localparam logic [1:0] ST_DNACK = 2'b10;
    localparam logic [1:0] ST_AL    = 2'b11;

    state_t           state;
    logic [6:0]       addr_q;
    logic             rnw_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [1:0]       status_q;
    // Set while a command is outstanding. A command is only raised when
    // this is clear, so the cycle after every ack is all-low.
    logic             cmd_busy;

    logic [LEN_W-1:0] cnt_next;
    logic [LEN_W-1:0] len_m1;

    assign cnt_next = cnt_q + LEN_W'(1);
    assign len_m1   = len_q - LEN_W'(1);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= IDLE;
            addr_q      <= '0;
            rnw_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            status_q    <= ST_OK;
            cmd_busy    <= 1'b0;
            req_ready   <= 1'b1;
            wdata_ready <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            done_valid  <= 1'b0;
            done_status <= '0;
            done_count  <= '0;
            bc_start    <= 1'b0;
            bc_stop     <= 1'b0;
            bc_read     <= 1'b0;
            bc_write    <= 1'b0;
            bc_ack_in   <= 1'b0;
            bc_din      <= '0;
        end else begin
            wdata_ready <= 1'b0;
            done_valid  <= 1'b0;
            // Arbitration loss wins over a same-cycle ack; the bus is no
            // longer ours, so no STOP is attempted.
            if (bc_al && state != IDLE && state != DONE) begin
                bc_start    <= 1'b0;
                bc_stop     <= 1'b0;
                bc_read     <= 1'b0;
                bc_write    <= 1'b0;
                bc_ack_in   <= 1'b0;
                cmd_busy    <= 1'b0;
                rdata_valid <= 1'b0;
                done_valid  <= 1'b1;
                done_status <= ST_AL;
                done_count  <= cnt_q;
                state       <= DONE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (req_valid && req_ready) begin
                            addr_q    <= req_addr;
                            // An address probe is always a write probe.
                            rnw_q     <= req_rnw && (req_len != '0);
                            len_q     <= req_len;
                            cnt_q     <= '0;
                            status_q  <= ST_OK;
                            req_ready <= 1'b0;
                            state     <= ADDR;
                        end
                    end
                    ADDR: begin
                        if (!cmd_busy) begin
                            bc_start <= 1'b1;
                            bc_write <= 1'b1;
                            bc_din   <= {addr_q, rnw_q};
                            cmd_busy <= 1'b1;
                        end else if (bc_cmd_ack) begin
                            bc_start <= 1'b0;
                            bc_write <= 1'b0;
                            cmd_busy <= 1'b0;
                            if (bc_ack_out) begin
                                status_q <= ST_ANACK;
                                state    <= STOP;
                            end else if (len_q == '0) begin
                                state <= STOP;
                            end else if (rnw_q) begin
                                state <= RBYTE;
                            end else begin
                                state <= WGET;
                            end
                        end
                    end
                    WGET: begin
                        if (wdata_valid) begin
                            wdata_ready <= 1'b1;
                            bc_din      <= wdata;
                            state       <= WBYTE;
                        end
                    end
                    WBYTE: begin
                        if (!cmd_busy) begin
                            bc_write <= 1'b1;
                            cmd_busy <= 1'b1;
                        end else if (bc_cmd_ack) begin
                            bc_write <= 1'b0;
                            cmd_busy <= 1'b0;
                            if (bc_ack_out) begin
                                status_q <= ST_DNACK;
                                state    <= STOP;
                            end else begin
                                cnt_q <= cnt_next;
                                state <= (cnt_next == len_q) ? STOP : WGET;
                            end
                        end
                    end
                    RBYTE: begin
                        if (!cmd_busy) begin
                            bc_read   <= 1'b1;
                            // NACK the final byte to end the slave's read.
                            bc_ack_in <= (cnt_q == len_m1);
                            cmd_busy  <= 1'b1;
                        end else if (bc_cmd_ack) begin
                            bc_read     <= 1'b0;
                            bc_ack_in   <= 1'b0;
                            cmd_busy    <= 1'b0;
                            rdata       <= bc_dout;
                            rdata_valid <= 1'b1;
                            state       <= RPUSH;
                        end
                    end
                    RPUSH: begin
                        if (rdata_ready) begin
                            rdata_valid <= 1'b0;
                            cnt_q       <= cnt_next;
                            state <= (cnt_next == len_q) ? STOP : RBYTE;
                        end
                    end
                    STOP: begin
                        if (!cmd_busy) begin
                            bc_stop  <= 1'b1;
                            cmd_busy <= 1'b1;
                        end else if (bc_cmd_ack) begin
                            bc_stop     <= 1'b0;
                            cmd_busy    <= 1'b0;
                            done_valid  <= 1'b1;
                            done_status <= status_q;
                            done_count  <= cnt_q;
                            state       <= DONE;
                        end
                    end
                    DONE: begin
                        // done_valid is high during this cycle.
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
